// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - parameterised up/down counter with load, clamp, wrap and boundary pulse
// Optional saturate mode is enabled by defining CNT_SATURATE_EN (adds the sat input).
module up_down_counter_param #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef CNT_SATURATE_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] cnt,
   output logic             ovf,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_next;
   logic             ovf_next;
   logic             sat_mode;

`ifdef CNT_SATURATE_EN
   assign sat_mode = sat;
`else
   assign sat_mode = 1'b0;
`endif

   // Boundaries are detected by comparison before stepping, so the +1/-1 never
   // has to represent a value outside WIDTH bits even when MAX_VAL is all ones.
   always_comb begin
      cnt_next = cnt;
      ovf_next = 1'b0;
      if (load) begin
         cnt_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end else if (en) begin
         if (up_dn) begin
            if (cnt >= MAX_VAL) begin
               ovf_next = 1'b1;
               cnt_next = sat_mode ? MAX_VAL : '0;
            end else begin
               cnt_next = cnt + ONE;
            end
         end else begin
            if (cnt == '0) begin
               ovf_next = 1'b1;
               cnt_next = sat_mode ? '0 : MAX_VAL;
            end else begin
               cnt_next = cnt - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         cnt <= cnt_next;
         ovf <= ovf_next;
      end
   end

   assign zero = (cnt == '0);

endmodule
